// File: rtl/board_xfer_scheduler.sv
// Round-robin burst scheduler: grants one of NUM_BOARDS requesters per burst and holds the grant
// until the latched beat count has transferred or the stall timer expires.
module board_xfer_scheduler #(
    parameter int unsigned NUM_BOARDS = 8,   // board_sel encoding limits this to 8
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned TIMEOUT    = 255  // 1 .. 2^16-1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_BOARDS-1:0]       req,
    input  logic [NUM_BOARDS*LEN_W-1:0] burst_len,
    input  logic [NUM_BOARDS-1:0]       data_valid,
    output logic [NUM_BOARDS-1:0]       grant,
    output logic [3:0]                  board_sel,
    output logic                        beat_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout_err
);

    localparam logic [3:0]  SEL_NONE  = 4'd8;
    localparam logic [15:0] STALL_MAX = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t                state;
    logic [3:0]            last_idx;
    logic [LEN_W-1:0]      beat_cnt;
    logic [15:0]           stall_cnt;

    logic                  found_hi;
    logic [3:0]            win_hi;
    logic [3:0]            win_lo;
    logic [3:0]            winner;
    logic [NUM_BOARDS-1:0] winner_oh;
    logic [LEN_W-1:0]      winner_len;
    logic                  beat;

    // Descending scan so the lowest qualifying index is the one that sticks.
    always_comb begin
        found_hi = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = NUM_BOARDS - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_lo = 4'(i);
                if (i > int'(last_idx)) begin
                    win_hi   = 4'(i);
                    found_hi = 1'b1;
                end
            end
        end
        winner = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        winner_oh  = '0;
        winner_len = '0;
        for (int i = 0; i < NUM_BOARDS; i++) begin
            if (4'(i) == winner) begin
                winner_oh[i] = 1'b1;
                winner_len   = burst_len[i*LEN_W +: LEN_W];
            end
        end
    end

    assign beat_ready = (state == XFER);
    assign busy       = (state != IDLE);
    // grant is one-hot on the selected board while in XFER, so this picks its valid only.
    assign beat       = beat_ready & |(data_valid & grant);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            board_sel   <= SEL_NONE;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            last_idx    <= 4'(NUM_BOARDS - 1);
            beat_cnt    <= '0;
            stall_cnt   <= '0;
        end else begin
            done        <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        grant     <= winner_oh;
                        board_sel <= winner;
                        last_idx  <= winner;
                        beat_cnt  <= winner_len;
                        stall_cnt <= '0;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (beat) begin
                        stall_cnt <= '0;
                        if (beat_cnt == '0) begin
                            done      <= 1'b1;
                            grant     <= '0;
                            board_sel <= SEL_NONE;
                            state     <= GAP;
                        end else begin
                            beat_cnt <= beat_cnt - LEN_W'(1);
                        end
                    end else if (stall_cnt == STALL_MAX) begin
                        timeout_err <= 1'b1;
                        grant       <= '0;
                        board_sel   <= SEL_NONE;
                        state       <= GAP;
                    end else if (stall_cnt != 16'hFFFF) begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_xfer_scheduler.sv
// Directed bench for board_xfer_scheduler; expected bursts are queued on stimulus and
// popped when the DUT grants.
module tb_board_xfer_scheduler;

    localparam int NB  = 8;
    localparam int LW  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] req;
    logic [NB*LW-1:0] burst_len;
    logic [NB-1:0] data_valid;
    logic [NB-1:0] grant;
    logic [3:0]    board_sel;
    logic          beat_ready;
    logic          busy;
    logic          done;
    logic          timeout_err;

    board_xfer_scheduler #(
        .NUM_BOARDS (NB),
        .LEN_W      (LW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .burst_len   (burst_len),
        .data_valid  (data_valid),
        .grant       (grant),
        .board_sel   (board_sel),
        .beat_ready  (beat_ready),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int board;
        int beats;
        bit to;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int b, input int v);
        burst_len[b*LW +: LW] = LW'(v);
    endtask

    task automatic push(input int b, input int beats, input bit to);
        exp_t e;
        e.board = b;
        e.beats = beats;
        e.to    = to;
        sb.push_back(e);
    endtask

    // Waits for a grant, then counts accepted beats until done/timeout_err. pat != 0 makes the
    // granted board's valid low every pat-th XFER cycle.
    task automatic observe_burst(input int pat, output int wait_n);
        exp_t e;
        int   n;
        int   beats;
        wait_n = 0;
        while (grant === '0 && wait_n < 20) begin
            tick();
            wait_n++;
        end
        check("grant_seen", 32'(grant !== '0), 1);
        check("sb_pending", 32'(sb.size() > 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("grant", grant, 32'(1 << e.board));
        check("board_sel", board_sel, e.board);
        check("xfer_busy", busy, 1);
        n     = 0;
        beats = 0;
        while (done !== 1'b1 && timeout_err !== 1'b1 && n < 2000) begin
            if (pat != 0) data_valid[e.board] = (n % pat) != 0;
            if (beat_ready && data_valid[e.board]) beats++;
            tick();
            n++;
        end
        check("beats", beats, e.beats);
        check("done", done, 32'(!e.to));
        check("timeout_err", timeout_err, 32'(e.to));
        if (e.to) check("timeout_cycles", n, TMO);
        check("gap_grant", grant, 0);
        check("gap_sel", board_sel, 8);
        check("gap_busy", busy, 1);
        check("gap_ready", beat_ready, 0);
        tick();
        check("idle_pulses", {30'd0, done, timeout_err}, 0);
        check("idle_busy", busy, 0);
        check("idle_grant", grant, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int  w;
        bit  bad;
        rst_n      = 1'b0;
        req        = '0;
        burst_len  = '0;
        data_valid = '0;

        // Reset and quiet idle
        tick();
        tick();
        check("rst_grant", grant, 0);
        check("rst_sel", board_sel, 8);
        check("rst_busy", busy, 0);
        check("rst_ready", beat_ready, 0);
        rst_n = 1'b1;
        bad   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (grant !== '0 || board_sel !== 4'd8 || busy !== 1'b0 || beat_ready !== 1'b0 ||
                done !== 1'b0 || timeout_err !== 1'b0) bad = 1'b1;
        end
        check("idle_quiet", bad, 0);

        // Single 4-beat burst on board 0; req drop and len change after grant are ignored
        set_len(0, 3);
        data_valid = 8'h01;
        req        = 8'h01;
        push(0, 4, 1'b0);
        tick();
        check("latency_grant", grant, 8'h01);
        req = 8'h00;
        set_len(0, 0);
        observe_burst(0, w);
        check("no_regrant", grant, 0);

        // Round robin from reset: 0..7 then 0, one grant every 3 cycles
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        burst_len  = '0;
        data_valid = 8'hFF;
        req        = 8'hFF;
        for (int i = 0; i < 9; i++) push(i % NB, 1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            observe_burst(0, w);
            check("rr_period", w, 1);
        end
        req = 8'h00;

        // Wrap-around: last_idx = 4, then req 0x90 gives 7 then 4
        req = 8'h10;
        push(4, 1, 1'b0);
        observe_burst(0, w);
        req = 8'h90;
        push(7, 1, 1'b0);
        push(4, 1, 1'b0);
        observe_burst(0, w);
        check("wrap_period", w, 1);
        observe_burst(0, w);
        check("wrap_period", w, 1);
        req = 8'h00;

        // Stall timeout on board 2; other boards' valid must not count
        set_len(2, 5);
        data_valid = 8'hFB;
        req        = 8'h04;
        push(2, 0, 1'b1);
        observe_burst(0, w);
        req = 8'h00;

        // Intermittent stalls: 3 beats on board 1
        set_len(1, 2);
        req = 8'h02;
        push(1, 3, 1'b0);
        observe_burst(3, w);
        req = 8'h00;

        // Maximum length burst: 256 beats on board 5 with alternating stalls
        set_len(5, 255);
        req = 8'h20;
        push(5, 256, 1'b0);
        observe_burst(2, w);
        req = 8'h00;

        // Reset in the middle of a board-3 burst
        set_len(3, 10);
        data_valid = 8'h00;
        req        = 8'h08;
        w          = 0;
        while (grant === '0 && w < 5) begin
            tick();
            w++;
        end
        check("b3_grant", grant, 8'h08);
        req = 8'h00;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        req   = 8'h09;
        tick();
        check("mid_rst_grant", grant, 0);
        check("mid_rst_sel", board_sel, 8);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pulses", {30'd0, done, timeout_err}, 0);
        set_len(0, 0);
        data_valid = 8'h01;
        rst_n      = 1'b1;
        push(0, 1, 1'b0);
        observe_burst(0, w);
        check("post_rst_latency", w, 1);
        req = 8'h00;

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
